// File: rtl/toggle_line_pkg.sv
// rtl/toggle_line_pkg.sv - shared states, defaults and frame-length helper for toggle_line_tx
package toggle_line_pkg;

  typedef enum logic [2:0] {
    TLX_IDLE,
    TLX_SYNC,
    TLX_DATA,
    TLX_STUFF,
    TLX_STOP
  } tlx_state_t;

  localparam int TLX_WIDTH        = 8;
  localparam int TLX_CLKS_PER_BIT = 4;
  localparam int TLX_MAX_RUN      = 5;

  // Sync + data + stop bits, plus any stuffed bits, each CLKS_PER_BIT long.
  function automatic int tlx_frame_len(input int width, input int stuff_count,
                                       input int clks_per_bit);
    return (2 + width + stuff_count) * clks_per_bit;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// rtl/bit_tick_gen.sv - bit period timer with restart, bit_start and bit_end strobes
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_start,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_start = (cnt == '0);
  assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));

  // Wraps on its own at bit_end so every bit period restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/toggle_line_tx.sv
// rtl/toggle_line_tx.sv - toggle-coded serial line transmitter with sync, stuffing and stop bits
module toggle_line_tx
  import toggle_line_pkg::*;
#(
  parameter int WIDTH        = TLX_WIDTH,
  parameter int CLKS_PER_BIT = TLX_CLKS_PER_BIT,
  parameter int MAX_RUN      = TLX_MAX_RUN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             t_out,
  output logic             tx_line,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(MAX_RUN + 1);

  tlx_state_t       state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [RW-1:0]    run_cnt;
  logic [RW-1:0]    run_inc;
  logic             cur_bit;
  logic             load;
  logic             bit_start;
  logic             bit_end;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (state == TLX_IDLE),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  assign busy    = (state != TLX_IDLE);
  assign run_inc = run_cnt + RW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TLX_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    cur_bit    = 1'b0;
    case (state)
      TLX_IDLE: begin
        if (in_valid && in_ready) begin
          next_state = TLX_SYNC;
          load       = 1'b1;
        end
      end
      TLX_SYNC: begin
        cur_bit = 1'b1;
        if (bit_end) next_state = TLX_DATA;
      end
      TLX_DATA: begin
        cur_bit = shreg[0];
        // A stuff bit takes priority over STOP when the run fills on the last data bit.
        if (bit_end) begin
          if (!shreg[0] && (run_inc == RW'(MAX_RUN))) next_state = TLX_STUFF;
          else if (bit_cnt == BW'(WIDTH - 1))         next_state = TLX_STOP;
        end
      end
      TLX_STUFF: begin
        cur_bit = 1'b1;
        if (bit_end) next_state = (bit_cnt == BW'(WIDTH)) ? TLX_STOP : TLX_DATA;
      end
      TLX_STOP: begin
        if (bit_end) next_state = TLX_IDLE;
      end
      default: next_state = TLX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      run_cnt  <= '0;
      tx_line  <= 1'b0;
      t_out    <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      in_ready <= (next_state == TLX_IDLE);
      if (busy && bit_start) begin
        t_out   <= cur_bit;
        tx_line <= tx_line ^ cur_bit;
      end else begin
        t_out <= 1'b0;
      end
      case (state)
        TLX_IDLE: begin
          if (load) begin
            shreg   <= in_data;
            bit_cnt <= '0;
            run_cnt <= '0;
          end
        end
        TLX_SYNC: run_cnt <= '0;
        TLX_DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BW'(1);
            run_cnt <= shreg[0] ? '0 : run_inc;
          end
        end
        TLX_STUFF: begin
          if (bit_end) run_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_line_tx.sv
// tb/tb_toggle_line_tx.sv - scoreboard bench for toggle_line_tx over three parameter sets
module tb_toggle_line_tx;
  import toggle_line_pkg::*;

  localparam int W = 8;

  typedef struct {
    int           len;
    int           toggles;
    logic         line;
    logic [127:0] pat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0][W-1:0] in_data;
  logic [2:0]        in_valid;
  wire  [2:0]        in_ready;
  wire  [2:0]        t_out;
  wire  [2:0]        tx_line;
  wire  [2:0]        busy;

  int           chk_cnt  = 0;
  int           pass_cnt = 0;
  int           overlap  = 0;
  int           sel      = 0;
  logic [2:0]   exp_line = '0;
  exp_t         sb[$];

  always #5 clk = ~clk;

  toggle_line_tx #(.WIDTH(W), .CLKS_PER_BIT(1), .MAX_RUN(5)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .t_out(t_out[0]), .tx_line(tx_line[0]), .busy(busy[0]));

  toggle_line_tx #(.WIDTH(W), .CLKS_PER_BIT(4), .MAX_RUN(5)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .t_out(t_out[1]), .tx_line(tx_line[1]), .busy(busy[1]));

  toggle_line_tx #(.WIDTH(W), .CLKS_PER_BIT(1), .MAX_RUN(8)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .t_out(t_out[2]), .tx_line(tx_line[2]), .busy(busy[2]));

  function automatic int cpb_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int mr_of(input int i);
    return (i == 2) ? 8 : 5;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Builds the line-bit sequence (sync, data with stuffing, stop) and the t_out pattern it implies.
  function automatic exp_t model(input logic [W-1:0] data, input int cpb, input int mr,
                                 input logic line0);
    exp_t        e;
    logic [31:0] seq;
    int          n;
    int          run;
    seq = '0;
    n   = 0;
    run = 0;
    seq[n] = 1'b1; n++;
    for (int i = 0; i < W; i++) begin
      seq[n] = data[i]; n++;
      if (data[i]) run = 0;
      else run++;
      if (run == mr) begin
        seq[n] = 1'b1; n++;
        run = 0;
      end
    end
    seq[n] = 1'b0; n++;
    e.len     = tlx_frame_len(W, n - 2 - W, cpb);
    e.toggles = 0;
    e.pat     = '0;
    for (int b = 0; b < n; b++) begin
      if (seq[b]) begin
        e.toggles++;
        e.pat[b * cpb + 1] = 1'b1;
      end
    end
    e.line = line0 ^ e.toggles[0];
    return e;
  endfunction

  logic         prev_busy = 1'b0;
  int           cyc  = 0;
  int           togs = 0;
  logic [127:0] obs  = '0;
  exp_t         got_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      cyc  = 0;
      togs = 0;
      obs  = '0;
    end else begin
      if (busy[sel] && in_ready[sel]) overlap++;
      if (busy[sel]) begin
        if (t_out[sel]) begin
          togs++;
          if (cyc < 128) obs[cyc] = 1'b1;
        end
        cyc++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          got_e = sb.pop_front();
          check_val("frame_len", cyc, got_e.len);
          check_val("toggles", togs, got_e.toggles);
          check_val("final_line", tx_line[sel], got_e.line);
          check_val("t_out_pattern", obs, got_e.pat);
        end
        cyc  = 0;
        togs = 0;
        obs  = '0;
      end
      prev_busy = busy[sel];
    end
  end

  task automatic wait_ready(input int idx);
    int t = 0;
    while (!in_ready[idx] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[idx]) check_val("ready_timeout", 0, 1);
  endtask

  task automatic push_exp(input int idx, input logic [W-1:0] data);
    exp_t e;
    e = model(data, cpb_of(idx), mr_of(idx), exp_line[idx]);
    exp_line[idx] = e.line;
    sb.push_back(e);
  endtask

  task automatic send(input int idx, input logic [W-1:0] data);
    sel = idx;
    wait_ready(idx);
    in_data[idx]  = data;
    in_valid[idx] = 1'b1;
    push_exp(idx, data);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    check_val("busy_on_accept", busy[idx], 1);
    check_val("ready_drop", in_ready[idx], 0);
  endtask

  task automatic wait_done(input int idx);
    int t = 0;
    while (busy[idx] && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy[idx]) check_val("done_timeout", 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int gap;
    rst      = 1'b1;
    in_data  = '0;
    in_valid = '0;
    #1;
    check_val("rst_in_ready", in_ready, 3'b000);
    check_val("rst_busy", busy, 3'b000);
    check_val("rst_tx_line", tx_line, 3'b000);
    check_val("rst_t_out", t_out, 3'b000);
    @(posedge clk); #3;
    rst = 1'b0;
    check_val("ready_before_edge", in_ready[0], 0);
    @(posedge clk); #1;
    check_val("ready_after_release", in_ready, 3'b111);

    send(0, 8'hA5);
    check_val("sync_latency_t0", t_out[0], 0);
    @(posedge clk); #1;
    check_val("sync_latency_t1", t_out[0], 1);
    check_val("sync_line", tx_line[0], 1);
    wait_done(0);

    send(0, 8'h00);
    wait_done(0);

    send(1, 8'hFF);
    wait_done(1);

    send(2, 8'h00);
    wait_done(2);

    // Back-to-back with in_valid held high; 8'h80 is presented during the first frame.
    sel = 0;
    wait_ready(0);
    in_data[0]  = 8'h01;
    in_valid[0] = 1'b1;
    push_exp(0, 8'h01);
    @(posedge clk); #1;
    in_data[0] = 8'h80;
    push_exp(0, 8'h80);
    gap = 0;
    while (busy[0] && gap < 200) begin
      @(posedge clk); #1;
      gap++;
    end
    gap = 0;
    while (!busy[0] && gap < 20) begin
      @(posedge clk); #1;
      gap++;
    end
    check_val("b2b_idle_gap", gap, 1);
    in_valid[0] = 1'b0;
    wait_done(0);

    // Reset in the middle of DATA, then a full retransmission.
    sel = 0;
    wait_ready(0);
    in_data[0]  = 8'h5A;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_val("busy_pre_rst", busy[0], 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_tx_line", tx_line[0], 0);
    check_val("midrst_t_out", t_out[0], 0);
    check_val("midrst_busy", busy[0], 0);
    check_val("midrst_in_ready", in_ready[0], 0);
    exp_line = '0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("ready_after_midrst", in_ready[0], 1);
    send(0, 8'h5A);
    wait_done(0);

    for (int k = 0; k < 4; k++) begin
      send(k % 2, W'($urandom_range(0, 255)));
      wait_done(k % 2);
    end
    send(2, 8'h10);
    wait_done(2);

    check_val("ready_while_busy", overlap, 0);
    check_val("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
